// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader, fetch path and instruction memory.
// State encodings are plain constants so legacy decode logic can compare against them.
package instruction_loader_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/instruction_loader_checksum.sv
// Running byte sum for the load image; chk_ok says whether sum + check byte wraps to zero.
module loader_checksum
  import instruction_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clr,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_data,
  input  logic [DATA_W-1:0] chk_data,
  output logic              chk_ok
);

  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] total;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       sum_q <= '0;
    else if (clr)    sum_q <= '0;
    else if (add_en) sum_q <= sum_q + add_data;
  end

  // Truncation to DATA_W gives the mod 2^DATA_W arithmetic for free.
  assign total  = sum_q + chk_data;
  assign chk_ok = (total == '0);

endmodule

// File: rtl/instruction_loader.sv
// Streams a program into instruction memory from address 0 and holds the CPU until a clean load.
// Optional trailing checksum byte: define INSTRUCTION_LOADER_CHECKSUM_EN.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W:0]   Load_Len,
  input  logic              In_Valid,
  input  logic [DATA_W-1:0] In_Data,
  output logic              In_Ready,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  output logic              Cpu_Hold,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  localparam logic [1:0] ST_AFTER_LOAD = ST_CHECK;
`else
  localparam logic [1:0] ST_AFTER_LOAD = ST_FINISH;
`endif

  logic [1:0]        state, state_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt, len_q, start_len;
  logic              in_rdy, transfer, load_xfer, last_byte, start_acc;
  logic              err_q, err_nxt;

  // Clamping here is what keeps Mem_Addr from ever wrapping past DEPTH-1.
  assign start_len = (Load_Len > LEN_MAX) ? LEN_MAX : Load_Len;

  assign in_rdy    = (state == ST_LOAD) || (state == ST_CHECK);
  assign transfer  = In_Valid && in_rdy;
  assign load_xfer = transfer && (state == ST_LOAD);
  assign cnt_nxt   = cnt + 1'b1;
  assign last_byte = (cnt_nxt == len_q);

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          start_acc = 1'b1;
          state_nxt = (start_len == '0) ? ST_FINISH : ST_LOAD;
        end
      end
      ST_LOAD:   if (load_xfer && last_byte) state_nxt = ST_AFTER_LOAD;
      ST_CHECK:  if (transfer) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic chk_ok;

  loader_checksum #(.DATA_W(DATA_W)) u_checksum (
    .Clk      (Clk),
    .Reset    (Reset),
    .clr      (start_acc),
    .add_en   (load_xfer),
    .add_data (In_Data),
    .chk_data (In_Data),
    .chk_ok   (chk_ok)
  );

  always_comb begin
    err_nxt = err_q;
    if (start_acc)                             err_nxt = 1'b0;
    else if ((state == ST_CHECK) && transfer)  err_nxt = !chk_ok;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) err_q <= 1'b0;
    else       err_q <= err_nxt;
  end
`else
  assign err_nxt = 1'b0;
  assign err_q   = 1'b0;
`endif

  assign Error    = err_q;
  assign In_Ready = in_rdy;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      len_q     <= '0;
      Mem_WE    <= 1'b0;
      Mem_Addr  <= '0;
      Mem_WData <= '0;
      Cpu_Hold  <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      state  <= state_nxt;
      Busy   <= (state_nxt == ST_LOAD) || (state_nxt == ST_CHECK);
      Done   <= (state_nxt == ST_FINISH);
      Mem_WE <= load_xfer;
      if (start_acc) begin
        len_q <= start_len;
        cnt   <= '0;
      end else if (load_xfer) begin
        cnt <= cnt_nxt;
      end
      if (load_xfer) begin
        Mem_Addr  <= cnt[ADDR_W-1:0];
        Mem_WData <= In_Data;
      end
      // Registered so the fetch unit's async reset never sees a glitch.
      if (state_nxt == ST_FINISH)  Cpu_Hold <= err_nxt;
      else if (start_acc)          Cpu_Hold <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: writes go through a scoreboard queue checked by a monitor.
module tb_instruction_loader;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [8:0] Load_Len = '0;
  logic       In_Valid = 1'b0;
  logic [7:0] In_Data = '0;
  logic       In_Ready, Mem_WE, Cpu_Hold, Busy, Done, Error;
  logic [7:0] Mem_Addr, Mem_WData;

  instruction_loader dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Load_Len(Load_Len),
    .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(In_Ready),
    .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Cpu_Hold(Cpu_Hold), .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;

  int   checks = 0, errors = 0;
  int   wr_cnt = 0, done_cnt = 0, exp_addr = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  logic [7:0] imem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (Done) done_cnt++;
      if (Mem_WE) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", Mem_Addr, Mem_WData);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", {24'd0, Mem_Addr}, {24'd0, mon_e.addr});
          chk("wr_data", {24'd0, Mem_WData}, {24'd0, mon_e.data});
        end
      end
    end
  end

  // Instruction memory model, read back as the fetch path would.
  always @(posedge Clk) if (Mem_WE) imem[Mem_Addr] <= Mem_WData;

  task automatic cyc();
    @(posedge Clk); #1;
  endtask

  task automatic start(input int len);
    Start = 1'b1; Load_Len = 9'(len);
    cyc();
    Start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit push);
    bit hs;
    int n;
    hs = 0; n = 0;
    In_Valid = 1'b1; In_Data = b;
    while (!hs && n < 50) begin
      @(negedge Clk);
      hs = In_Ready;
      if (hs && push) begin
        exp_q.push_back({8'(exp_addr), b});
        exp_addr++;
      end
      @(posedge Clk); #1;
      n++;
    end
    In_Valid = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no In_Ready expected handshake");
    end
  endtask

  task automatic wait_done(input string name, input bit exp_hold, output int n);
    bit found;
    found = 0; n = 0;
    while (!found && n < 20) begin
      @(negedge Clk);
      n++;
      if (Done) found = 1;
    end
    chk({name, "_done"}, {31'd0, found}, 32'd1);
    if (found) begin
      chk({name, "_hold"}, {31'd0, Cpu_Hold}, {31'd0, exp_hold});
      chk({name, "_busy"}, {31'd0, Busy}, 32'd0);
    end
  endtask

  initial begin
    int n, w0, d0;
    logic [7:0] b4 [4];
    b4[0] = 8'h11; b4[1] = 8'h22; b4[2] = 8'h33; b4[3] = 8'h44;

    // Power-up
    repeat (3) cyc();
    chk("rst_hold", {31'd0, Cpu_Hold}, 32'd1);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_ready", {31'd0, In_Ready}, 32'd0);
    chk("rst_we", {31'd0, Mem_WE}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_err", {31'd0, Error}, 32'd0);
    Reset = 1'b0;
    repeat (20) cyc();
    chk("idle_hold", {31'd0, Cpu_Hold}, 32'd1);
    chk("idle_busy", {31'd0, Busy}, 32'd0);
    chk("idle_ready", {31'd0, In_Ready}, 32'd0);
    chk("idle_writes", wr_cnt, 0);
    chk("idle_dones", done_cnt, 0);

    // Back-to-back load of 4 bytes
    exp_addr = 0; w0 = wr_cnt; d0 = done_cnt;
    start(4);
    for (int i = 0; i < 4; i++) send(b4[i], 1);
    wait_done("load4", 1'b0, n);
    repeat (3) cyc();
    chk("load4_drain", exp_q.size(), 0);
    chk("load4_writes", wr_cnt - w0, 4);
    chk("load4_dones", done_cnt - d0, 1);
    chk("fetch_pc0", {24'd0, imem[0]}, 32'h11);
    chk("fetch_pc3", {24'd0, imem[3]}, 32'h44);
    chk("load4_err", {31'd0, Error}, 32'd0);

    // Gapped load with a Start pulse mid-load
    exp_addr = 0; w0 = wr_cnt;
    start(4);
    @(negedge Clk);
    chk("gap_hold_set", {31'd0, Cpu_Hold}, 32'd1);
    chk("gap_busy", {31'd0, Busy}, 32'd1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      send(b4[i] + 8'h01, 1);
      if (i == 1) begin
        Start = 1'b1; Load_Len = 9'd1;
        cyc();
        Start = 1'b0;
        cyc();
      end else if (i < 3) begin
        repeat (2) cyc();
      end
    end
    wait_done("gap", 1'b0, n);
    cyc();
    chk("gap_drain", exp_q.size(), 0);
    chk("gap_writes", wr_cnt - w0, 4);

    // Zero-length load
    w0 = wr_cnt;
    start(0);
    wait_done("len0", 1'b0, n);
    chk("len0_latency", n, 1);
    repeat (2) cyc();
    chk("len0_writes", wr_cnt - w0, 0);

    // Over-length load clamps to DEPTH
    exp_addr = 0; w0 = wr_cnt;
    start(300);
    for (int i = 0; i < 256; i++) send(8'(i ^ 8'hA5), 1);
    wait_done("len300", 1'b0, n);
    repeat (2) cyc();
    chk("len300_writes", wr_cnt - w0, 256);
    chk("len300_drain", exp_q.size(), 0);
    chk("len300_last", {24'd0, imem[255]}, {24'd0, 8'(255 ^ 8'hA5)});

    // Reset mid-load
    exp_addr = 0;
    start(4);
    send(8'h11, 1);
    send(8'h22, 1);
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_hold", {31'd0, Cpu_Hold}, 32'd1);
    chk("mid_rst_busy", {31'd0, Busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, In_Ready}, 32'd0);
    chk("mid_rst_we", {31'd0, Mem_WE}, 32'd0);
    chk("mid_rst_addr", {24'd0, Mem_Addr}, 32'd0);
    chk("mid_rst_wdata", {24'd0, Mem_WData}, 32'd0);
    chk("mid_rst_done", {31'd0, Done}, 32'd0);
    repeat (2) cyc();
    Reset = 1'b0;
    exp_q.delete();
    exp_addr = 0; w0 = wr_cnt;
    cyc();
    start(1);
    send(8'h5A, 1);
    wait_done("after_rst", 1'b0, n);
    cyc();
    chk("after_rst_writes", wr_cnt - w0, 1);
    chk("after_rst_pc0", {24'd0, imem[0]}, 32'h5A);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    exp_addr = 0; w0 = wr_cnt;
    start(2);
    send(8'h01, 1); send(8'h02, 1); send(8'hFD, 0);
    wait_done("csum_ok", 1'b0, n);
    chk("csum_ok_err", {31'd0, Error}, 32'd0);
    cyc();
    chk("csum_ok_writes", wr_cnt - w0, 2);
    exp_addr = 0; w0 = wr_cnt;
    start(2);
    send(8'h01, 1); send(8'h02, 1); send(8'hFE, 0);
    wait_done("csum_bad", 1'b1, n);
    chk("csum_bad_err", {31'd0, Error}, 32'd1);
    cyc();
    chk("csum_bad_writes", wr_cnt - w0, 2);
    chk("csum_bad_hold", {31'd0, Cpu_Hold}, 32'd1);
`endif

    repeat (2) cyc();
    chk("final_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

endmodule
